// File: rtl/hazard_unit.sv
// Hazard unit: load-use stall, taken-branch flush and memory-wait freeze.
// Stall/flush controls decode combinationally from the FSM state and current inputs.
module hazard_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Rs_ID,
  input  logic [1:0]       Rt_ID,
  input  logic             Rs_used_ID,
  input  logic             Rt_used_ID,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       Rd_EX,
  input  logic             Branch_taken_EX,
  input  logic             MemAccess_MEM,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             Pipe_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       scnt_q, scnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_wait;
  logic load_use;

  assign mem_wait = MemAccess_MEM & ~mem_ready;
  assign load_use = MemRead_EX & RegWrite_EX &
                    ((Rs_used_ID & (Rs_ID == Rd_EX)) |
                     (Rt_used_ID & (Rt_ID == Rd_EX)));

  // Priority decode: reset, memory wait, branch, flush window, load-use.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    Pipe_Stall   = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    scnt_d       = scnt_q;
    priority case (1'b1)
      !rst: begin
        state_d = RUN;
      end
      mem_wait: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        Pipe_Stall   = 1'b1;
        MEM_WB_Flush = 1'b1;
        if (state_q != MEM_WAIT) begin
          saved_d = state_q;
          scnt_d  = cnt_q;
          state_d = MEM_WAIT;
        end
      end
      Branch_taken_EX: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        cnt_d       = FC;
        state_d     = (FC != 2'd0) ? FLUSH : RUN;
      end
      (state_q == FLUSH): begin
        IF_ID_Flush = 1'b1;
        cnt_d       = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
        state_d     = (cnt_q <= 2'd1) ? RUN : FLUSH;
      end
      default: begin
        if (state_q == MEM_WAIT) begin
          state_d = saved_q;
          cnt_d   = scnt_q;
        end
        if (load_use) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
    endcase
  end

  // FSM state, flush counter and the context saved across a memory wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= 2'd0;
      scnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Saturating count of cycles where the PC is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (!PC_Write && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1: extra cycles IF_ID_Flush stays high after the taken-branch cycle; range 0-3.
REQ-002 Parameter CNT_W, default 16: stall_cnt width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 Rs_ID, Rt_ID  in  2 each  source register addresses of the instruction in ID.
REQ-006 Rs_used_ID, Rt_used_ID  in  1 each  the instruction in ID reads that source.
REQ-007 MemRead_EX, RegWrite_EX  in  1 each  the instruction in EX is a load / writes a register.
REQ-008 Rd_EX  in  2  destination register of the instruction in EX.
REQ-009 Branch_taken_EX  in  1  a branch resolved taken in EX.
REQ-010 MemAccess_MEM  in  1  the instruction in MEM uses the shared memory port.
REQ-011 mem_ready  in  1  memory completes the access this cycle.
REQ-012 PC_Write, IF_ID_Write  out  1 each  enables; 0 freezes PC / IF-ID.
REQ-013 Pipe_Stall  out  1  freezes ID/EX and EX/MEM.
REQ-014 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble into that register.
REQ-015 stall_cnt  out  CNT_W  saturating count of cycles with PC_Write=0.

Function
REQ-016 FSM states: RUN, MEM_WAIT, FLUSH; stall outputs decode combinationally from state and current inputs, with no added latency.
REQ-017 Default in RUN, no hazard: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
REQ-018 Memory wait (highest priority): MemAccess_MEM=1 and mem_ready=0 in any state sets PC_Write=0, IF_ID_Write=0, Pipe_Stall=1, MEM_WB_Flush=1, other flushes 0.
REQ-019 The memory-wait condition moves RUN or FLUSH to MEM_WAIT and saves the interrupted state and flush count.
REQ-020 MEM_WAIT holds while mem_ready=0.
REQ-021 mem_ready=1 in MEM_WAIT gives normal decode that cycle, then returns to the saved state with the saved count.
REQ-022 Taken branch (second priority): Branch_taken_EX=1 with no memory wait sets IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
REQ-023 If FLUSH_CYCLES>0, the taken branch loads the flush counter with FLUSH_CYCLES and moves to FLUSH; if FLUSH_CYCLES=0, the FSM stays in RUN.
REQ-024 FLUSH: IF_ID_Flush=1 and the counter decrements each cycle; the FSM returns to RUN when the counter reaches 0.
REQ-025 A new Branch_taken_EX in FLUSH reloads the counter.
REQ-026 Load-use (lowest priority), asserted when MemRead_EX & RegWrite_EX & ((Rs_used_ID & Rs_ID==Rd_EX) | (Rt_used_ID & Rt_ID==Rd_EX)).
REQ-027 Load-use response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly that cycle; no state change (one bubble; the forwarding unit covers MEM->EX afterward).
REQ-028 Branch and load-use in the same cycle: branch response only, with no PC freeze.
REQ-029 Load-use is not evaluated in FLUSH, because the ID instruction is being flushed.
REQ-030 A taken branch frozen in EX by memory wait (Branch_taken_EX held) acts once, on the release cycle.
REQ-031 stall_cnt increments by 1 on each clock edge where PC_Write=0, and saturates at all-ones with no wrap.

Reset
REQ-032 rst=0 asynchronously forces state=RUN, flush counter=0, saved state=RUN, stall_cnt=0.
REQ-033 While rst=0, outputs read PC_Write=1, IF_ID_Write=1, all flushes and Pipe_Stall 0; a reset in MEM_WAIT or FLUSH abandons it.

Verification
REQ-034 Load R2 in EX (Rd_EX=2, MemRead_EX=1, RegWrite_EX=1), ID Rt_ID=2, Rt_used_ID=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cnt 0->1; next cycle normal.
REQ-035 Same but Rt_used_ID=0, or Rd_EX=3 -> no stall, stall_cnt unchanged.
REQ-036 Branch_taken_EX pulse 1 cycle, FLUSH_CYCLES=1 -> IF_ID_Flush high 2 cycles, ID_EX_Flush high 1 cycle, PC_Write never 0.
REQ-037 MemAccess_MEM=1, mem_ready=0 for 3 cycles then 1 -> Pipe_Stall/MEM_WB_Flush high 3 cycles, stall_cnt +3, release on 4th.
REQ-038 Branch taken coincident with load-use match -> branch response only, stall_cnt unchanged.
REQ-039 Memory wait entered from FLUSH (counter=1), reset pulsed mid-wait -> all outputs at reset values immediately, stall_cnt=0, RUN after release.
